ps2_key_rx: RTL and testbench
=============================

# ps2_key_rx

Upstream keyboard front end for the Lynx machine. It receives raw PS/2 device-to-host frames from the keyboard clock/data pins and filters the lines. It checks framing and odd parity, resolves the E0/F0 prefixes, and presents each completed key event as an 11-bit `ps2_key` word for the keyboard-matrix logic inside `lynx48`.

## Interface
Parameters:
- `FILTER_LEN`, 8: consecutive identical samples required before the filtered PS/2 clock changes level (range 2–255).
- `TIMEOUT_CYC`, 96000: maximum `clock` cycles allowed between falling edges inside a frame (2 ms at 48 MHz).

Ports:
- `clock`  in  1  system clock (`clk_sys`).
- `reset`  in  1  asynchronous, active-high reset.
- `ps2_clk_i`  in  1  raw PS/2 clock pin, asynchronous.
- `ps2_dat_i`  in  1  raw PS/2 data pin, asynchronous.
- `ps2_key_o`  out  11  key event word:
  - [10]: toggles on every event.
  - [9]: 1 = press, 0 = release.
  - [8]: extended (E0) key.
  - [7:0]: scancode.
- `key_stb_o`  out  1  one-cycle pulse in the cycle `ps2_key_o` is updated.
- `err_o`  out  1  one-cycle pulse when a frame is rejected (start, parity, stop or timeout).
- `busy_o`  out  1  high while a frame is in progress (state ≠ IDLE).

## Operation
- Both pins pass through a 2-flop synchroniser. Reset value of the synchroniser is 1 (idle bus).
- Clock glitch filter:
  - A counter tracks consecutive synchronised samples that differ from the filtered level.
  - When the counter reaches `FILTER_LEN`, the filtered level flips and the counter clears.
  - Any sample equal to the filtered level clears the counter.
- A falling edge is a filtered-level 1→0 transition. Data is sampled from the synchronised data line in that cycle.
- Frame FSM states:
  - IDLE: on edge with data=0 → DATA, bit count 0. Edge with data=1 is ignored and stays in IDLE.
  - DATA: shift bits in LSB first. After the 8th bit → PARITY.
  - PARITY: latch the parity bit → STOP.
  - STOP: on edge, the frame is accepted if the stop bit is 1 and the XOR of 8 data bits and the parity bit is 1. Either way → IDLE.
- Timeout: a cycle counter clears on every edge. If it reaches `TIMEOUT_CYC` in a non-IDLE state → IDLE and `err_o` pulses.
- Rejected frame (start, parity, stop or timeout): `err_o` pulses, and the ext, release and skip flags all clear.
- Accepted byte decode, in priority order:
  - skip count > 0: decrement it, emit nothing.
  - E1: load skip = 7 (swallows the Pause sequence), emit nothing.
  - E0: set ext, emit nothing.
  - F0: set release, emit nothing.
  - AA, FA, FE, EE with no prefix pending: discard.
  - Otherwise: emit {~toggle_prev, ~release, ext, code}, pulse `key_stb_o`, clear ext and release.
- Reset values:
  - `ps2_key_o` = 11'h000.
  - `key_stb_o`, `err_o`, `busy_o` = 0.
  - FSM in IDLE; all flags and counters 0.

## Timing
- Filter latency: the filtered clock changes `FILTER_LEN` + 2 cycles after a clean pin edge.
- An accepted byte is registered in the cycle after the stop-bit edge. `ps2_key_o` and `key_stb_o` update one cycle later, so output latency is 2 cycles after that edge.
- `err_o` for a bad parity or stop bit asserts at the same latency as `key_stb_o` would have.
- `err_o` for a timeout asserts in the cycle after the counter hits `TIMEOUT_CYC`.
- Simultaneous timeout and edge: the edge wins and the timeout counter clears.
- Reset mid-frame: the partial frame is discarded with no `err_o`, and the next start bit is honoured.
- The bit counter saturates; only the FSM state advances the phase.

## Structure
- Shared package `lynx_kbd_pkg`:
  - state enum `ps2_state_t` {IDLE, DATA, PARITY, STOP}.
  - constants PS2_EXT=8'hE0, PS2_REL=8'hF0, PS2_PAUSE=8'hE1, PAUSE_SKIP=3'd7, the discard list bytes.
  - `ps2_key` field bit positions.
- One sub-module: `ps2_line_filter` (synchroniser plus glitch filter plus falling-edge detect). It is instantiated once for the clock line; the data line uses only its synchroniser path.

## Test plan
- Frame 0x1C with parity 0 and stop 1, bit period 80 µs → after 2 cycles, `ps2_key_o`=11'h61C (toggle 1, press, code 1C) and `key_stb_o` pulses once.
- Sequence E0 F0 75 → exactly one event, `ps2_key_o`[9:0]=10'h175 with [9]=0 and [8]=1, and the toggle flips relative to the previous event.
- Frame 0x1C with parity forced to 1 → `err_o` pulses, no `key_stb_o`; a following valid 0x1C is emitted with ext=0 and release=0.
- Stop clock after 4 data bits for `TIMEOUT_CYC`+10 cycles → `err_o` pulses once and `busy_o` falls. A fresh 0x29 frame then emits code 29.
- Clock glitches of `FILTER_LEN`−1 cycles injected mid-bit → no extra edges and the byte decodes correctly. The Pause sequence E1 14 77 E1 F0 14 F0 77 → zero events.
- Assert `reset` during the PARITY phase → all outputs are 0 and the FSM is in IDLE. The next frame 0x5A decodes normally.

Source files
------------

// File: rtl/lynx_kbd_pkg.sv
// Shared definitions for the Lynx PS/2 keyboard front end: frame states,
// special scancodes and the layout of the ps2_key event word.
package lynx_kbd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_REL    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  // Controller status bytes that never map to a key
  localparam logic [7:0] PS2_BAT_OK = 8'hAA;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;

  localparam int unsigned KEY_TOGGLE_BIT = 10;
  localparam int unsigned KEY_PRESS_BIT  = 9;
  localparam int unsigned KEY_EXT_BIT    = 8;
  localparam int unsigned KEY_CODE_MSB   = 7;
  localparam int unsigned KEY_W          = 11;

  function automatic logic is_discard(input logic [7:0] code);
    return (code == PS2_BAT_OK) || (code == PS2_ACK) ||
           (code == PS2_RESEND) || (code == PS2_ECHO);
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronisers for the PS/2 pins, glitch filter on the clock line
// and a registered falling-edge pulse of the filtered clock.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic ps2_clk_i,
  input  logic ps2_dat_i,
  output logic dat_sync_o,
  output logic fall_o
);

  localparam int unsigned CntW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic [1:0]      clk_sync_q, dat_sync_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            fall_q, fall_d;

  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    fall_d = 1'b0;
    if (clk_sync_q[1] != filt_q) begin
      if (cnt_q == CntW'(FILTER_LEN - 1)) begin
        filt_d = clk_sync_q[1];
        fall_d = ~clk_sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      cnt_q      <= '0;
      fall_q     <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[0], ps2_dat_i};
      filt_q     <= filt_d;
      cnt_q      <= cnt_d;
      fall_q     <= fall_d;
    end
  end

  assign dat_sync_o = dat_sync_q[1];
  assign fall_o     = fall_q;

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 device-to-host receiver: frames bytes, checks parity/stop/timeout and
// folds E0/F0/E1 prefixes into single 11-bit key events.
module ps2_key_rx
  import lynx_kbd_pkg::*;
#(
  parameter int unsigned FILTER_LEN  = 8,
  parameter int unsigned TIMEOUT_CYC = 96000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ps2_clk_i,
  input  logic              ps2_dat_i,
  output logic [KEY_W-1:0]  ps2_key_o,
  output logic              key_stb_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int unsigned ToW = $clog2(TIMEOUT_CYC + 1);

  logic dat_sync, fall;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clock      (clock),
    .reset      (reset),
    .ps2_clk_i  (ps2_clk_i),
    .ps2_dat_i  (ps2_dat_i),
    .dat_sync_o (dat_sync),
    .fall_o     (fall)
  );

  ps2_state_t       state_q, state_d;
  logic [3:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_q, par_d;
  logic [ToW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_vld_q, byte_vld_d;
  logic             frame_err_q, frame_err_d;
  logic             timeout_hit;

  logic             ext_q, ext_d;
  logic             rel_q, rel_d;
  logic [2:0]       skip_q, skip_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             stb_q, stb_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // Frame sequencer; an edge in the same cycle as a timeout takes priority
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    byte_d      = byte_q;
    byte_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    timeout_hit = 1'b0;
    if (fall) begin
      case (state_q)
        IDLE: begin
          if (!dat_sync) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shift_d = {dat_sync, shift_q[7:1]};
          if (bit_cnt_q != 4'd8) bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_sync;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_sync && (^{shift_q, par_q})) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE && to_cnt_q == ToW'(TIMEOUT_CYC)) begin
      timeout_hit = 1'b1;
      state_d     = IDLE;
    end

    if (fall || state_q == IDLE) begin
      to_cnt_d = '0;
    end else if (to_cnt_q != ToW'(TIMEOUT_CYC)) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end else begin
      to_cnt_d = to_cnt_q;
    end
  end

  // Byte decoder: prefixes accumulate until a plain code emits an event
  always_comb begin
    ext_d  = ext_q;
    rel_d  = rel_q;
    skip_d = skip_q;
    key_d  = key_q;
    stb_d  = 1'b0;
    err_d  = frame_err_q | timeout_hit;
    busy_d = (state_d != IDLE);
    if (frame_err_q || timeout_hit) begin
      ext_d  = 1'b0;
      rel_d  = 1'b0;
      skip_d = '0;
    end else if (byte_vld_q) begin
      if (skip_q != '0) begin
        skip_d = skip_q - 3'd1;
      end else if (byte_q == PS2_PAUSE) begin
        skip_d = PAUSE_SKIP;
      end else if (byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else if (byte_q == PS2_REL) begin
        rel_d = 1'b1;
      end else if (is_discard(byte_q) && !ext_q && !rel_q) begin
        key_d = key_q;
      end else begin
        key_d[KEY_TOGGLE_BIT]   = ~key_q[KEY_TOGGLE_BIT];
        key_d[KEY_PRESS_BIT]    = ~rel_q;
        key_d[KEY_EXT_BIT]      = ext_q;
        key_d[KEY_CODE_MSB:0]   = byte_q;
        stb_d                   = 1'b1;
        ext_d                   = 1'b0;
        rel_d                   = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      to_cnt_q    <= '0;
      byte_q      <= '0;
      byte_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      skip_q      <= '0;
      key_q       <= '0;
      stb_q       <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      to_cnt_q    <= to_cnt_d;
      byte_q      <= byte_d;
      byte_vld_q  <= byte_vld_d;
      frame_err_q <= frame_err_d;
      ext_q       <= ext_d;
      rel_q       <= rel_d;
      skip_q      <= skip_d;
      key_q       <= key_d;
      stb_q       <= stb_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign ps2_key_o = key_q;
  assign key_stb_o = stb_q;
  assign err_o     = err_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Directed bench for ps2_key_rx: drives PS/2 frames on the pins and checks
// emitted key words, strobe/error counts, busy and latency.
module tb_ps2_key_rx;

  localparam int unsigned FL = 4;
  localparam int unsigned TO = 200;
  localparam int unsigned H  = 20;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [10:0] ps2_key;
  logic        key_stb, err, busy;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  int stb_cyc = 0;
  int last_fall_cyc = 0;
  logic [10:0] last_key = '0;

  ps2_key_rx #(
    .FILTER_LEN  (FL),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .ps2_clk_i (ps2_clk),
    .ps2_dat_i (ps2_dat),
    .ps2_key_o (ps2_key),
    .key_stb_o (key_stb),
    .err_o     (err),
    .busy_o    (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (key_stb) begin
      ev_cnt   <= ev_cnt + 1;
      last_key <= ps2_key;
      stb_cyc  <= cyc;
    end
    if (err) err_cnt <= err_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b, input logic glitch);
    @(posedge clock);
    #1 ps2_dat = b;
    if (glitch) begin
      repeat (8) @(posedge clock);
      #1 ps2_clk = 1'b0;
      repeat (FL - 1) @(posedge clock);
      #1 ps2_clk = 1'b1;
      repeat (H - 8 - (FL - 1)) @(posedge clock);
    end else begin
      repeat (H) @(posedge clock);
    end
    #1 ps2_clk = 1'b0;
    last_fall_cyc = cyc;
    repeat (H) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n, input logic glitch);
    for (int i = 0; i < n; i++) ps2_bit(bits[i], glitch);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic bad_par, input logic glitch);
    logic par;
    par = (~^d) ^ bad_par;
    send_bits({1'b1, par, d, 1'b0}, 11, glitch);
    repeat (4) @(posedge clock);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    repeat (3) @(posedge clock);
    #1;
    chk("reset_key", 32'(ps2_key), 32'h000);
    chk("reset_flags", {29'd0, key_stb, err, busy}, 32'd0);
    reset = 1'b0;
    repeat (5) @(posedge clock);

    // Single press of 0x1C
    send_byte(8'h1C, 1'b0, 1'b0);
    chk("t1_events", ev_cnt, 1);
    chk("t1_key", 32'(last_key), 32'h61C);
    chk("t1_latency", stb_cyc - last_fall_cyc, FL + 4);
    chk("t1_noerr", err_cnt, 0);
    chk("t1_idle", 32'(busy), 0);

    // Extended release
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0);
    chk("t2_events", ev_cnt, 2);
    chk("t2_key", 32'(last_key), 32'h175);

    // Bad parity after prefixes clears them
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h1C, 1'b1, 1'b0);
    chk("t3_err", err_cnt, 1);
    chk("t3_noev", ev_cnt, 2);
    send_byte(8'h1C, 1'b0, 1'b0);
    chk("t3_events", ev_cnt, 3);
    chk("t3_key", 32'(last_key), 32'h61C);

    // Timeout after start + 4 data bits
    send_bits({1'b1, 1'b0, 8'h29, 1'b0}, 5, 1'b0);
    chk("t4_busy", 32'(busy), 1);
    repeat (TO + 10) @(posedge clock);
    #1;
    chk("t4_err", err_cnt, 2);
    chk("t4_idle", 32'(busy), 0);
    chk("t4_noev", ev_cnt, 3);
    send_byte(8'h29, 1'b0, 1'b0);
    chk("t4_events", ev_cnt, 4);
    chk("t4_key", 32'(last_key), 32'h229);

    // Sub-threshold clock glitches mid-bit
    send_byte(8'h66, 1'b0, 1'b1);
    chk("t5_events", ev_cnt, 5);
    chk("t5_key", 32'(last_key), 32'h666);
    chk("t5_noerr", err_cnt, 2);

    // Pause sequence and a status byte emit nothing
    for (int i = 0; i < 8; i++) send_byte(pause_seq[i], 1'b0, 1'b0);
    chk("pause_noev", ev_cnt, 5);
    send_byte(8'hAA, 1'b0, 1'b0);
    chk("discard_noev", ev_cnt, 5);
    send_byte(8'h16, 1'b0, 1'b0);
    chk("post_pause_events", ev_cnt, 6);
    chk("post_pause_key", 32'(last_key), 32'h216);
    chk("pause_noerr", err_cnt, 2);

    // Reset during PARITY phase
    send_bits({1'b1, 1'b1, 8'h5A, 1'b0}, 9, 1'b0);
    chk("t6_busy", 32'(busy), 1);
    @(posedge clock);
    #1 reset = 1'b1;
    #2;
    chk("t6_reset_key", 32'(ps2_key), 32'h000);
    chk("t6_reset_flags", {29'd0, key_stb, err, busy}, 32'd0);
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    repeat (5) @(posedge clock);
    send_byte(8'h5A, 1'b0, 1'b0);
    chk("t6_events", ev_cnt, 7);
    chk("t6_key", 32'(last_key), 32'h65A);
    chk("t6_noerr", err_cnt, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
